// File: rtl/alu_issuer_pkg.sv
// Shared types for the ALU command issuer: command record layout and widths.
// ALU_ISSUER_ACCUM_EN adds the accumulate bit to the command record.
package alu_issuer_pkg;

   localparam int ALU_W = 8;

   typedef struct packed {
`ifdef ALU_ISSUER_ACCUM_EN
      logic             acc;
`endif
      logic             cin;
      logic             op;
      logic [1:0]       sel;
      logic [ALU_W-1:0] b;
      logic [ALU_W-1:0] a;
   } cmd_t;

   localparam int CMD_W = $bits(cmd_t);

endpackage

// File: rtl/alu_cmd_issuer_cmd_fifo.sv
// Synchronous command FIFO; storage is unreset, pointers and count reset.
module cmd_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push,
   input  logic                   pop,
   input  logic [W-1:0]           din,
   output logic [W-1:0]           dout,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;

   assign dout  = mem[rd_ptr];
   assign full  = (count == FULL_CNT);
   assign empty = (count == '0);

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= din;
   end

   // Power-of-2 depth lets the pointers wrap naturally.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/alu_cmd_issuer.sv
// Valid/ready sequencing around an external combinational ALU: FIFO -> issue regs -> response regs.
// ALU_ISSUER_ACCUM_EN adds cmd_acc, chaining the previous result into operand A.
module alu_cmd_issuer
   import alu_issuer_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int WIDTH = ALU_W
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   cmd_valid,
   output logic                   cmd_ready,
   input  logic [WIDTH-1:0]       cmd_a,
   input  logic [WIDTH-1:0]       cmd_b,
   input  logic [1:0]             cmd_sel,
   input  logic                   cmd_op,
   input  logic                   cmd_cin,
`ifdef ALU_ISSUER_ACCUM_EN
   input  logic                   cmd_acc,
`endif
   output logic [WIDTH-1:0]       alu_a,
   output logic [WIDTH-1:0]       alu_b,
   output logic                   alu_s1,
   output logic                   alu_s0,
   output logic                   alu_op,
   output logic                   alu_cin,
   input  logic [WIDTH-1:0]       alu_result,
   input  logic                   alu_overflow,
   input  logic [WIDTH-1:0]       alu_remainder,
   output logic                   rsp_valid,
   input  logic                   rsp_ready,
   output logic [WIDTH-1:0]       rsp_result,
   output logic                   rsp_overflow,
   output logic [WIDTH-1:0]       rsp_remainder,
   output logic [$clog2(DEPTH):0] fifo_count
);

   cmd_t       in_cmd, head;
   logic       full, empty, push, pop;
   logic       i_valid, r_free, i_adv;
   logic [WIDTH-1:0] next_a;

   always_comb begin
      in_cmd     = '0;
      in_cmd.a   = cmd_a;
      in_cmd.b   = cmd_b;
      in_cmd.sel = cmd_sel;
      in_cmd.op  = cmd_op;
      in_cmd.cin = cmd_cin;
`ifdef ALU_ISSUER_ACCUM_EN
      in_cmd.acc = cmd_acc;
`endif
   end

   assign cmd_ready = !rst && !full;
   assign push      = cmd_valid && cmd_ready;
   assign r_free    = !rsp_valid || rsp_ready;
   assign i_adv     = i_valid && r_free;
   assign pop       = !empty && (!i_valid || i_adv);

   cmd_fifo #(.DEPTH(DEPTH), .W(CMD_W)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .din   (in_cmd),
      .dout  (head),
      .full  (full),
      .empty (empty),
      .count (fifo_count)
   );

`ifdef ALU_ISSUER_ACCUM_EN
   logic [WIDTH-1:0] acc;

   // If the predecessor is retiring on this same edge its result is still on the ALU output.
   always_comb begin
      next_a = head.a;
      if (head.acc) next_a = i_adv ? alu_result : acc;
   end

   always_ff @(posedge clk) begin
      if (rst)        acc <= '0;
      else if (i_adv) acc <= alu_result;
   end
`else
   assign next_a = head.a;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         i_valid <= 1'b0;
         alu_a   <= '0;
         alu_b   <= '0;
         alu_s1  <= 1'b0;
         alu_s0  <= 1'b0;
         alu_op  <= 1'b0;
         alu_cin <= 1'b0;
      end else if (pop) begin
         i_valid <= 1'b1;
         alu_a   <= next_a;
         alu_b   <= head.b;
         alu_s1  <= head.sel[1];
         alu_s0  <= head.sel[0];
         alu_op  <= head.op;
         alu_cin <= head.cin;
      end else if (i_adv) begin
         i_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rsp_valid     <= 1'b0;
         rsp_result    <= '0;
         rsp_overflow  <= 1'b0;
         rsp_remainder <= '0;
      end else if (i_adv) begin
         rsp_valid     <= 1'b1;
         rsp_result    <= alu_result;
         rsp_overflow  <= alu_overflow;
         rsp_remainder <= alu_remainder;
      end else if (rsp_ready) begin
         rsp_valid     <= 1'b0;
      end
   end

endmodule
